router_fifo_depacketizer: RTL and testbench

Receive-side counterpart of the FIFO-to-router packetizer at a NoC endpoint. Accepts HEAD/BODY/TAIL/HEADTAIL flits from the router local output port and rebuilds the original FIFO word stream: one header word, then the data words. The length field is not carried in the flit, so the block buffers each packet store-and-forward, counts its data flits, then writes the reconstructed header and the buffered data into the endpoint write FIFO.

---
 rtl/router_fifo_depacketizer.sv | 221 ++++++++++++++++++++++
 tb/tb_router_fifo_depacketizer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_depacketizer.sv
// router_fifo_depacketizer: rebuilds the endpoint FIFO word stream (header
// word followed by data words) from HEAD/BODY/TAIL/HEADTAIL flits delivered
// by the router local output port. Packets are buffered store-and-forward
// because the length field only becomes known once the TAIL arrives.
// Optional feature macro: NOC_DEPKT_ERR_CNT_EN adds the err_cnt port and a
// saturating 8-bit protocol error counter.
// HEAD/HEADTAIL flit data layout: [W-1:W-4] x_dest, [W-5:W-8] y_dest,
// [W-9:W-11] l_dest, [W-20:0] head_pl; bits [W-12:W-19] are the slot that
// the reconstructed header fills with the data-flit count.

package router_fifo_depacketizer_pkg;
  localparam int FLIT_DATA_SIZE = 32;
  localparam int VC_NUM         = 2;
  localparam int VC_ID_W        = 1;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_ID_W-1:0]          vc_id;
    logic [FLIT_DATA_SIZE-1:0]   data;
  } flit_t;
endpackage

module router_fifo_depacketizer
  import router_fifo_depacketizer_pkg::*;
#(
  parameter int PKT_BUF_DEPTH = 16,
  parameter int ON_OFF_MARGIN = 3
) (
  input  logic                      clk_router,
  input  logic                      rst_router_n,
  input  flit_t                     router_data_out,
  input  logic                      router_valid_out,
  output logic [VC_NUM-1:0]         router_is_on_off_in,
  output logic [VC_NUM-1:0]         router_is_allocatable_in,
  input  logic                      router_wrbuf_wafull,
  output logic                      router_wrbuf_wen,
  output logic [FLIT_DATA_SIZE-1:0] router_wrbuf_wdata,
  output logic                      pkt_err
`ifdef NOC_DEPKT_ERR_CNT_EN
  ,
  output logic [7:0]                err_cnt
`endif
);

  localparam int W  = FLIT_DATA_SIZE;
  localparam int AW = (PKT_BUF_DEPTH > 1) ? $clog2(PKT_BUF_DEPTH) : 1;
  localparam logic [7:0] DEPTH_C = 8'(PKT_BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WR_HEAD, S_DRAIN, S_DISCARD
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           rd_q, rd_d;
  logic [VC_ID_W-1:0]   vc_q, vc_d;
  logic [W-9:0]         hdr_q, hdr_d;       // {x, y, l, head_pl} without len
  logic                 wen_q, wen_d;
  logic [W-1:0]         wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [VC_NUM-1:0]    on_off_q, on_off_d;
  logic                 buf_we;
  logic                 start_pkt;
  logic [VC_NUM-1:0]    vc_onehot;
  logic [W-1:0]         pkt_buf_q [PKT_BUF_DEPTH];

  logic is_head, is_tail, vc_match;
  assign is_head  = (router_data_out.flit_label == FLIT_HEAD) ||
                    (router_data_out.flit_label == FLIT_HEADTAIL);
  assign is_tail  = (router_data_out.flit_label == FLIT_TAIL);
  assign vc_match = (router_data_out.vc_id == vc_q);

  // Next-state, FIFO write and on/off computation for the depacketizer FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    vc_d      = vc_q;
    hdr_d     = hdr_q;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    start_pkt = 1'b0;
    vc_onehot = '0;
    vc_onehot[vc_q] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (router_valid_out) begin
          if (is_head) start_pkt = 1'b1;
          else         err_d     = 1'b1;
        end
      end
      S_COLLECT: begin
        if (router_valid_out) begin
          if (is_head) begin
            // a new header aborts the packet in progress
            err_d     = 1'b1;
            start_pkt = 1'b1;
          end else if (!vc_match) begin
            err_d = 1'b1;
          end else if (cnt_q == DEPTH_C) begin
            // overflow: a TAIL already ends the packet, otherwise flush to it
            err_d   = 1'b1;
            state_d = is_tail ? S_IDLE : S_DISCARD;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (is_tail) state_d = S_WR_HEAD;
          end
        end
      end
      S_DISCARD: begin
        if (router_valid_out) begin
          if (is_head) begin
            err_d     = 1'b1;
            start_pkt = 1'b1;
          end else if (vc_match && is_tail) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WR_HEAD: begin
        if (router_valid_out) err_d = 1'b1;
        if (!router_wrbuf_wafull) begin
          wen_d   = 1'b1;
          wdata_d = {hdr_q[W-9:W-19], cnt_q, hdr_q[W-20:0]};
          rd_d    = 8'd0;
          state_d = (cnt_q == 8'd0) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (router_valid_out) err_d = 1'b1;
        if (!router_wrbuf_wafull) begin
          wen_d   = 1'b1;
          wdata_d = pkt_buf_q[rd_q[AW-1:0]];
          rd_d    = rd_q + 8'd1;
          if (rd_q == cnt_q - 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_pkt) begin
      hdr_d   = {router_data_out.data[W-1:W-11], router_data_out.data[W-20:0]};
      vc_d    = router_data_out.vc_id;
      cnt_d   = 8'd0;
      state_d = (router_data_out.flit_label == FLIT_HEADTAIL) ? S_WR_HEAD : S_COLLECT;
    end

    case (state_q)
      S_IDLE:    on_off_d = '1;
      S_COLLECT: on_off_d = ((int'(cnt_q) + ON_OFF_MARGIN) < PKT_BUF_DEPTH) ? vc_onehot : '0;
      S_DISCARD: on_off_d = vc_onehot;
      default:   on_off_d = '0;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk_router or negedge rst_router_n) begin
    if (!rst_router_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rd_q     <= 8'd0;
      vc_q     <= '0;
      hdr_q    <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      on_off_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      vc_q     <= vc_d;
      hdr_q    <= hdr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      on_off_q <= on_off_d;
    end
  end

  // Packet data buffer; holds only payload, so it needs no reset
  always_ff @(posedge clk_router) begin
    if (buf_we) pkt_buf_q[cnt_q[AW-1:0]] <= router_data_out.data;
  end

  assign router_is_on_off_in      = on_off_q;
  assign router_is_allocatable_in = '1;
  assign router_wrbuf_wen         = wen_q;
  assign router_wrbuf_wdata       = wdata_q;
  assign pkt_err                  = err_q;

`ifdef NOC_DEPKT_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of protocol errors, stepped alongside the pkt_err pulse
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk_router or negedge rst_router_n) begin
    if (!rst_router_n) err_cnt_q <= 8'd0;
    else               err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_fifo_depacketizer.sv
// Testbench for router_fifo_depacketizer: table-driven cycle vectors for the
// basic packet and HEADTAIL cases, plus hand-written multi-cycle sequences
// for backpressure, overflow, protocol errors and mid-drain reset.

module tb_router_fifo_depacketizer;
  import router_fifo_depacketizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  flit_t       rdo;
  logic        rvalid;
  logic [1:0]  on_off;
  logic [1:0]  alloc;
  logic        wafull;
  logic        wen;
  logic [31:0] wdata;
  logic        err;
`ifdef NOC_DEPKT_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  router_fifo_depacketizer #(.PKT_BUF_DEPTH(16), .ON_OFF_MARGIN(3)) dut (
    .clk_router               (clk),
    .rst_router_n             (rst_n),
    .router_data_out          (rdo),
    .router_valid_out         (rvalid),
    .router_is_on_off_in      (on_off),
    .router_is_allocatable_in (alloc),
    .router_wrbuf_wafull      (wafull),
    .router_wrbuf_wen         (wen),
    .router_wrbuf_wdata       (wdata),
    .pkt_err                  (err)
`ifdef NOC_DEPKT_ERR_CNT_EN
    ,
    .err_cnt                  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_seen = 0;
  logic [31:0] wq[$];

  // write/err monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wen) wq.push_back(wdata);
    if (err) err_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rvalid = 1'b0;
    rdo    = '0;
  endtask

  task automatic send(input flit_label_t l, input logic vc, input logic [31:0] d);
    rvalid          = 1'b1;
    rdo.flit_label  = l;
    rdo.vc_id       = vc;
    rdo.data        = d;
    step();
    idle_in();
  endtask

  function automatic logic [31:0] mk_head(input int x, input int y, input int l, input int pl);
    return (32'(x) << 28) | (32'(y) << 24) | (32'(l) << 21) | (32'(pl) & 32'h1FFF);
  endfunction

  function automatic logic [31:0] mk_hdr(input int x, input int y, input int l, input int len, input int pl);
    return mk_head(x, y, l, pl) | ((32'(len) & 32'hFF) << 13);
  endfunction

  task automatic chk_queue(input string name, input logic [31:0] exp[$]);
    chk({name, "_count"}, 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      chk($sformatf("%s_w%0d", name, i), wq[i], exp[i]);
  endtask

  typedef struct {
    logic        vld;
    flit_label_t lbl;
    logic        vc;
    logic [31:0] data;
    logic        wafull;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic        e_err;
    logic [1:0]  e_onoff;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] exp_q[$];
    int e0;

    // vectors: HEAD(3,5,2,0x1A)+A1,A2,A3 then HEADTAIL(1,2,3,0x55) on VC1
    tbl[0]  = '{1'b1, FLIT_HEAD,     1'b0, 32'h3540001A, 1'b0, 1'b0, 32'h0,        1'b0, 2'b11};
    tbl[1]  = '{1'b1, FLIT_BODY,     1'b0, 32'h000000A1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b01};
    tbl[2]  = '{1'b1, FLIT_BODY,     1'b0, 32'h000000A2, 1'b0, 1'b0, 32'h0,        1'b0, 2'b01};
    tbl[3]  = '{1'b1, FLIT_TAIL,     1'b0, 32'h000000A3, 1'b0, 1'b0, 32'h0,        1'b0, 2'b01};
    tbl[4]  = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b1, 32'h3540601A, 1'b0, 2'b00};
    tbl[5]  = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b1, 32'h000000A1, 1'b0, 2'b00};
    tbl[6]  = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b1, 32'h000000A2, 1'b0, 2'b00};
    tbl[7]  = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b1, 32'h000000A3, 1'b0, 2'b00};
    tbl[8]  = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 2'b11};
    tbl[9]  = '{1'b1, FLIT_HEADTAIL, 1'b1, 32'h12600055, 1'b0, 1'b0, 32'h0,        1'b0, 2'b11};
    tbl[10] = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b1, 32'h12600055, 1'b0, 2'b00};
    tbl[11] = '{1'b0, FLIT_HEAD,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 2'b11};

    idle_in();
    wafull = 1'b0;
    rst_n  = 1'b0;
    step();
    step();

    // reset state
    chk("rst_wen",    32'(wen),    32'd0);
    chk("rst_wdata",  wdata,       32'd0);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_onoff",  32'(on_off), 32'd3);
    chk("rst_alloc",  32'(alloc),  32'd3);
`ifdef NOC_DEPKT_ERR_CNT_EN
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // table-driven cycle vectors
    for (int i = 0; i < 12; i++) begin
      rvalid         = tbl[i].vld;
      rdo.flit_label = tbl[i].lbl;
      rdo.vc_id      = tbl[i].vc;
      rdo.data       = tbl[i].data;
      wafull         = tbl[i].wafull;
      step();
      chk($sformatf("v%0d_wen", i),   32'(wen),    32'(tbl[i].e_wen));
      if (tbl[i].e_wen)
        chk($sformatf("v%0d_wdata", i), wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_err", i),   32'(err),    32'(tbl[i].e_err));
      chk($sformatf("v%0d_onoff", i), 32'(on_off), 32'(tbl[i].e_onoff));
    end
    idle_in();
    step();

    // backpressure during drain: 5 data words, wafull high 4 cycles
    wq.delete();
    e0 = err_seen;
    send(FLIT_HEAD, 1'b0, mk_head(3, 5, 2, 'h1A));
    for (int k = 0; k < 4; k++) send(FLIT_BODY, 1'b0, 32'hB0 + 32'(k));
    send(FLIT_TAIL, 1'b0, 32'hB4);
    step();                            // header write
    step();                            // first data word
    wafull = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("bp_wen_held%0d", k), 32'(wen), 32'd0);
    end
    wafull = 1'b0;
    for (int k = 0; k < 10; k++) step();
    exp_q = {mk_hdr(3, 5, 2, 5, 'h1A), 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
    chk_queue("bp", exp_q);
    chk("bp_noerr", 32'(err_seen - e0), 32'd0);

    // BODY in IDLE, then a VC1 flit during VC0 collection
    wq.delete();
    e0 = err_seen;
    send(FLIT_BODY, 1'b0, 32'hDEAD);
    send(FLIT_HEAD, 1'b0, mk_head(7, 1, 4, 'h0F0));
    send(FLIT_BODY, 1'b0, 32'hC1);
    send(FLIT_BODY, 1'b1, 32'hEEEE);
    send(FLIT_TAIL, 1'b0, 32'hC2);
    for (int k = 0; k < 8; k++) step();
    chk("perr_pulses", 32'(err_seen - e0), 32'd2);
`ifdef NOC_DEPKT_ERR_CNT_EN
    chk("perr_errcnt", 32'(err_cnt), 32'd2);
`endif
    exp_q = {mk_hdr(7, 1, 4, 2, 'h0F0), 32'hC1, 32'hC2};
    chk_queue("perr", exp_q);

    // overflow: 17 data flits into a 16-deep buffer
    wq.delete();
    e0 = err_seen;
    send(FLIT_HEAD, 1'b0, mk_head(2, 2, 1, 'h3));
    for (int k = 1; k <= 16; k++) begin
      send(FLIT_BODY, 1'b0, 32'h100 + 32'(k));
      // on/off reflects the count before this flit; 3 slots left turns it off
      chk($sformatf("ovf_onoff%0d", k), 32'(on_off), ((k - 1) + 3 < 16) ? 32'd1 : 32'd0);
    end
    send(FLIT_TAIL, 1'b0, 32'h111);
    for (int k = 0; k < 20; k++) step();
    chk("ovf_err",    32'(err_seen - e0), 32'd1);
    chk("ovf_nowr",   32'(wq.size()),     32'd0);
    chk("ovf_onoff_idle", 32'(on_off),    32'd3);
    send(FLIT_HEAD, 1'b1, mk_head(9, 8, 7, 'h1234));
    send(FLIT_TAIL, 1'b1, 32'hF00D);
    for (int k = 0; k < 6; k++) step();
    exp_q = {mk_hdr(9, 8, 7, 1, 'h1234), 32'hF00D};
    chk_queue("ovf_next", exp_q);
    chk("ovf_next_err", 32'(err_seen - e0), 32'd1);

    // reset in the middle of draining an 8-word packet
    send(FLIT_HEAD, 1'b0, mk_head(4, 4, 4, 'h44));
    for (int k = 0; k < 7; k++) send(FLIT_BODY, 1'b0, 32'hD0 + 32'(k));
    send(FLIT_TAIL, 1'b0, 32'hD7);
    step();
    step();
    step();
    chk("rstd_wen_before", 32'(wen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstd_wen_now", 32'(wen),    32'd0);
    wq.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("rstd_nowr",   32'(wq.size()), 32'd0);
    chk("rstd_onoff",  32'(on_off),    32'd3);
    send(FLIT_HEAD, 1'b0, mk_head(1, 1, 1, 'h1));
    send(FLIT_BODY, 1'b0, 32'hE1);
    send(FLIT_TAIL, 1'b0, 32'hE2);
    for (int k = 0; k < 6; k++) step();
    exp_q = {mk_hdr(1, 1, 1, 2, 'h1), 32'hE1, 32'hE2};
    chk_queue("rstd_next", exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
